hiscore_ram_arbiter: RTL
========================

// Module: hiscore_ram_arbiter
// PURPOSE
//  Downstream of the hiscore engine: owns the game work-RAM port and arbitrates it between CPU and hiscore.
//  Stalls the CPU on a hiscore request and waits for the CPU bus to go idle before granting.
//  Muxes hiscore address/data/write onto the RAM; returns registered read data to the hiscore engine.
//  Guarantees clean hand-back: the guard cycles before release carry no RAM write.
// PARAMETERS
//  ADDRESSWIDTH  10  game RAM address width
//  SETTLE        2   idle cycles required after cpu_cs low before grant (1..15)
//  GUARD         1   cycles after grant drop with ram_we=0 before cpu_wait drops (1..15)
//  MAXHOLD       255 cycles in HOLD with cpu_cs high before forced grant (1..255)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  hs_req       in   1   hiscore wants RAM (hiscore pause output)
//  hs_address   in   ADDRESSWIDTH  hiscore RAM address
//  hs_data_in   in   8   hiscore write data
//  hs_write     in   1   hiscore write strobe
//  hs_grant     out  1   RAM owned by hiscore (registered)
//  hs_dout      out  8   registered RAM read data to hiscore
//  hs_wr_count  out  8   writes performed this grant, saturating at 255
//  cpu_cs       in   1   CPU RAM access in progress
//  cpu_address  in   ADDRESSWIDTH  CPU RAM address
//  cpu_data_in  in   8   CPU write data
//  cpu_write    in   1   CPU write strobe
//  cpu_wait     out  1   CPU stall / clock-enable inhibit (registered)
//  cpu_dout     out  8   RAM read data to CPU
//  ram_address  out  ADDRESSWIDTH  to game RAM
//  ram_data_in  out  8   to game RAM
//  ram_we       out  1   to game RAM
//  ram_data_out in   8   from game RAM (synchronous read, 1-cycle latency)
// BEHAVIOUR
//  Reset (async): state=IDLE; cpu_wait=0, hs_grant=0, hs_dout=0, hs_wr_count=0, counters=0; ram_we=0.
//  States: IDLE, HOLD, GRANT, RELEASE.
//  IDLE: CPU owns RAM. hs_req=1 -> HOLD, cpu_wait<=1, hold/settle counters cleared.
//  HOLD: cpu_wait=1, CPU still owns RAM (completes in-flight access).
//   - settle counter increments while cpu_cs=0, clears when cpu_cs=1; hold counter increments every cycle.
//   - settle==SETTLE or hold==MAXHOLD -> GRANT, hs_grant<=1, hs_wr_count<=0.
//   - hs_req drops in HOLD -> RELEASE (no grant issued).
//  GRANT: hiscore owns RAM; ram_we = hs_write; hs_wr_count += 1 per cycle with hs_write=1 (saturate 255).
//   - hs_req=0 -> RELEASE, hs_grant<=0; ram_we forced 0 from this cycle on.
//  RELEASE: hiscore owns mux, ram_we=0, GUARD cycles; then IDLE, cpu_wait<=0.
//   - hs_req high during RELEASE ignored; IDLE lasts >=1 cycle with cpu_wait=0 before next HOLD.
//  Mux (combinational): ram_address/ram_data_in from hiscore in GRANT and RELEASE, else from CPU.
//   ram_we = cpu_write in IDLE/HOLD; hs_write in GRANT; 0 in RELEASE.
//  hs_dout <= ram_data_out every GRANT cycle, held otherwise: data valid 2 clocks after hs_address.
//  cpu_dout = ram_data_out in IDLE/HOLD; holds last CPU-owned value during GRANT/RELEASE.
//  Counters wide enough for parameter max; no wrap. hs_wr_count holds after grant until next GRANT entry.
//  Async reset mid-GRANT: ram_we drops immediately, CPU regains RAM, cpu_wait=0.
// TESTING
//  hs_req=1, cpu_cs=0 from IDLE -> cpu_wait=1 next clk; hs_grant=1 after SETTLE=2 idle cycles (3rd edge).
//  cpu_cs=1 held 10 cycles during HOLD -> no grant until cpu_cs low 2 cycles; with MAXHOLD=4, cpu_cs stuck -> grant at hold=4.
//  GRANT, hs_write at addrs 0x100..0x104 data 0xA0..0xA4 -> RAM holds values, hs_wr_count=5; read 0x102 -> hs_dout=0xA2 2 clks later.
//  hs_req drop with hs_write=1 same cycle -> ram_we=0, GUARD=1 cycle, then cpu_wait=0; hs_req re-raised in RELEASE -> 1 IDLE cycle first.
//  Assert reset mid-GRANT -> all outputs at reset values without clock edge; CPU write 0x55 to 0x010 next cycle succeeds.
//  300 writes in one grant -> hs_wr_count saturates at 255.

Source files
------------

// File: rtl/hiscore_ram_arbiter.sv
// ============================================================================
//  Module   : hiscore_ram_arbiter
//  Function : Shares the game work-RAM port between the CPU and the hiscore
//             engine. The CPU is stalled and the bus must go idle before the
//             hiscore engine is granted. Guard cycles with no write precede
//             the hand-back to the CPU.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hiscore_ram_arbiter #(
    parameter int ADDRESSWIDTH = 10,
    parameter int SETTLE       = 2,
    parameter int GUARD        = 1,
    parameter int MAXHOLD      = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hs_req,
    input  logic [ADDRESSWIDTH-1:0] hs_address,
    input  logic [7:0]              hs_data_in,
    input  logic                    hs_write,
    output logic                    hs_grant,
    output logic [7:0]              hs_dout,
    output logic [7:0]              hs_wr_count,
    input  logic                    cpu_cs,
    input  logic [ADDRESSWIDTH-1:0] cpu_address,
    input  logic [7:0]              cpu_data_in,
    input  logic                    cpu_write,
    output logic                    cpu_wait,
    output logic [7:0]              cpu_dout,
    output logic [ADDRESSWIDTH-1:0] ram_address,
    output logic [7:0]              ram_data_in,
    output logic                    ram_we,
    input  logic [7:0]              ram_data_out
);

    localparam logic [3:0] c_settle  = 4'(SETTLE);
    localparam logic [3:0] c_guard   = 4'(GUARD);
    localparam logic [7:0] c_maxhold = 8'(MAXHOLD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] guard_q, guard_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] wr_count_q, wr_count_d;
    logic [7:0] hs_dout_q, hs_dout_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic       cpu_wait_q, cpu_wait_d;
    logic       hs_grant_q, hs_grant_d;
    logic       w_hs_owns;
    logic       w_ram_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            settle_q   <= 4'd0;
            guard_q    <= 4'd0;
            hold_q     <= 8'd0;
            wr_count_q <= 8'd0;
            hs_dout_q  <= 8'd0;
            cpu_dout_q <= 8'd0;
            cpu_wait_q <= 1'b0;
            hs_grant_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            guard_q    <= guard_d;
            hold_q     <= hold_d;
            wr_count_q <= wr_count_d;
            hs_dout_q  <= hs_dout_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_wait_q <= cpu_wait_d;
            hs_grant_q <= hs_grant_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        guard_d    = guard_q;
        hold_d     = hold_q;
        wr_count_d = wr_count_q;
        hs_dout_d  = hs_dout_q;
        cpu_dout_d = cpu_dout_q;
        cpu_wait_d = cpu_wait_q;
        hs_grant_d = hs_grant_q;
        w_hs_owns  = 1'b0;
        w_ram_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_ram_we   = cpu_write;
                cpu_dout_d = ram_data_out;
                if (hs_req) begin
                    state_d    = S_HOLD;
                    cpu_wait_d = 1'b1;
                    settle_d   = 4'd0;
                    hold_d     = 8'd0;
                end
            end
            S_HOLD: begin
                // CPU keeps the port so an access already in flight can finish.
                w_ram_we   = cpu_write;
                cpu_dout_d = ram_data_out;
                settle_d   = cpu_cs ? 4'd0 : settle_q + 4'd1;
                hold_d     = hold_q + 8'd1;
                if (!hs_req) begin
                    state_d = S_RELEASE;
                    guard_d = 4'd0;
                end else if (settle_d == c_settle || hold_d == c_maxhold) begin
                    state_d    = S_GRANT;
                    hs_grant_d = 1'b1;
                    wr_count_d = 8'd0;
                end
            end
            S_GRANT: begin
                w_hs_owns = 1'b1;
                // A write coinciding with the request drop is suppressed.
                w_ram_we  = hs_write & hs_req;
                hs_dout_d = ram_data_out;
                if (w_ram_we && wr_count_q != 8'hFF) begin
                    wr_count_d = wr_count_q + 8'd1;
                end
                if (!hs_req) begin
                    state_d    = S_RELEASE;
                    hs_grant_d = 1'b0;
                    guard_d    = 4'd0;
                end
            end
            S_RELEASE: begin
                w_hs_owns = 1'b1;
                guard_d   = guard_q + 4'd1;
                if (guard_d == c_guard) begin
                    state_d    = S_IDLE;
                    cpu_wait_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_address = w_hs_owns ? hs_address : cpu_address;
    assign ram_data_in = w_hs_owns ? hs_data_in : cpu_data_in;
    assign ram_we      = w_ram_we;
    assign cpu_dout    = w_hs_owns ? cpu_dout_q : ram_data_out;
    assign cpu_wait    = cpu_wait_q;
    assign hs_grant    = hs_grant_q;
    assign hs_dout     = hs_dout_q;
    assign hs_wr_count = wr_count_q;

endmodule

`default_nettype wire
